// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH) plus final borrow,
// one bit per clock LSB first, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic             r_br, r_borrow, r_busy, r_done;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_d, w_br_n, w_last;

  // start is only honoured outside SHIFT; requests while busy are dropped
  assign w_accept = start && (r_state != S_SHIFT);
  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_n   = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_nxt = S_DONE;
      S_DONE:  w_nxt = start ? S_SHIFT : S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt == S_SHIFT);
      r_done  <= (w_nxt == S_DONE);
    end
  end

  // Result shifts in from the MSB side so it is aligned after WIDTH steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_diff   <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_br   <= w_br_n;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) r_borrow <= w_br_n;
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign busy   = r_busy;
  assign done   = r_done;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor at WIDTH=4 and WIDTH=8,
// checked against a plain-arithmetic subtraction model.
module tb_serial_subtractor;
  logic       clk, rst_n, start;
  logic [3:0] a, b, diff;
  logic       borrow, busy, done;
  logic       rst8_n, start8;
  logic [7:0] a8, b8, diff8;
  logic       borrow8, busy8, done8;

  int n_chk  = 0;
  int n_pass = 0;

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .diff(diff), .borrow(borrow), .busy(busy), .done(done)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow(borrow8), .busy(busy8), .done(done8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // {borrow,diff}: borrow when a<b, diff is the difference wrapped to w bits
  function automatic int ref_sub(input int w, input int x, input int y);
    int d;
    d = (x - y) & ((1 << w) - 1);
    return ((x < y) ? (1 << w) : 0) | d;
  endfunction

  // Launch from the current negedge, return at the negedge where done is seen
  task automatic op4(input string tag, input int x, input int y,
                     output int res, output int bcyc, output bit ok);
    start = 1'b1; a = 4'(x); b = 4'(y);
    @(negedge clk);
    start = 1'b0; a = 4'($urandom); b = 4'($urandom);
    chk({tag, "_load_clr"}, {borrow, diff}, 0);
    bcyc = 0; ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) bcyc++;
      @(negedge clk);
    end
    res = {borrow, diff};
    chk({tag, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic op8(input int x, input int y, output int res, output bit ok);
    start8 = 1'b1; a8 = 8'(x); b8 = 8'(y);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done8) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    res = {borrow8, diff8};
    chk("w8_done_seen", int'(ok), 1);
  endtask

  task automatic run_w4;
    int  res, bcyc, cyc, last, nd, prev, gap;
    bit  ok;
    int  pa[3] = '{14, 7, 2};
    int  pb[3] = '{8, 14, 9};

    // Reset state
    #3 chk("rst_outputs", {diff, borrow, busy, done}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Test 1: single op, busy length and single-cycle done
    @(negedge clk);
    op4("t1", 6, 12, res, bcyc, ok);
    chk("t1_res", res, ref_sub(4, 6, 12));
    chk("t1_busy_cycles", bcyc, 4);
    @(negedge clk);
    chk("t1_done_pulse", int'(done), 0);
    chk("t1_hold", {borrow, diff}, ref_sub(4, 6, 12));

    // Test 2: start held high, back-to-back accepts from DONE
    @(negedge clk);
    start = 1'b1; a = 4'(pa[0]); b = 4'(pb[0]);
    cyc = 0; last = 0;
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk); cyc++;
        if (done) begin ok = 1'b1; break; end
        a = 4'($urandom); b = 4'($urandom);
      end
      chk("t2_done_seen", int'(ok), 1);
      chk("t2_res", {borrow, diff}, ref_sub(4, pa[k], pb[k]));
      if (k > 0) chk("t2_period", cyc - last, 5);
      last = cyc;
      if (k < 2) begin a = 4'(pa[k+1]); b = 4'(pb[k+1]); end
      else start = 1'b0;
    end

    // Test 3: start during busy is ignored
    @(negedge clk);
    start = 1'b1; a = 4'd3; b = 4'd1;
    @(negedge clk); start = 1'b0;
    chk("t3_busy", int'(busy), 1);
    @(negedge clk); start = 1'b1; a = 4'hF; b = 4'h0;
    @(negedge clk); start = 1'b0;
    nd = 0; res = -1;
    for (int c = 0; c < 12; c++) begin
      if (done) begin nd++; res = {borrow, diff}; end
      @(negedge clk);
    end
    chk("t3_done_count", nd, 1);
    chk("t3_res", res, ref_sub(4, 3, 1));

    // Test 4: async reset mid-operation
    start = 1'b1; a = 4'd9; b = 4'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1 chk("t4_async_rst", {diff, borrow, busy, done}, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    chk("t4_no_done", nd, 0);
    op4("t4", 5, 5, res, bcyc, ok);
    chk("t4_res", res, 0);
    prev = res;

    // Test 5: exhaustive pairs with random gaps, result held until next accept
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        gap = int'($urandom_range(0, 3));
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("t5_hold", {borrow, diff}, prev);
        end
        op4("t5", x, y, res, bcyc, ok);
        chk("t5_res", res, ref_sub(4, x, y));
        prev = ref_sub(4, x, y);
      end
  endtask

  task automatic run_w8;
    int res, prev, gap, x, y;
    bit ok;
    @(negedge clk); rst8_n = 1'b1;
    @(negedge clk);
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       begin x = 0;   y = 0;   end
        1:       begin x = 0;   y = 255; end
        2:       begin x = 255; y = 0;   end
        3:       begin x = 128; y = 128; end
        default: begin x = int'($urandom_range(0, 255)); y = int'($urandom_range(0, 255)); end
      endcase
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("w8_hold", {borrow8, diff8}, prev);
      end
      op8(x, y, res, ok);
      chk("w8_res", res, ref_sub(8, x, y));
      prev = ref_sub(8, x, y);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    rst8_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0;
    fork
      run_w4();
      run_w8();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
